// File: rtl/axis_frame_pkg.sv
// Shared types and helpers for the AXIS frame controller.
package axis_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_IN_W   = 8;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_CNT_W  = 16;
  localparam int ZEXT_MAX_W = 512;

  // Keeps the low w bits of v and clears everything above them.
  function automatic logic [ZEXT_MAX_W-1:0] zext(input logic [ZEXT_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [ZEXT_MAX_W-1:0] mask;
    mask = '1;
    mask = mask >> (ZEXT_MAX_W - w);
    return v & mask;
  endfunction

endpackage

// File: rtl/axis_frame_ctrl_skid.sv
// Two-entry register slice; in_ready_o comes only from local state, so there is
// no combinational path from out_ready_i back to the input side.
module axis_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i,
  output logic         empty_o
);

  logic         main_valid_q, skid_valid_q;
  logic [W-1:0] main_data_q, skid_data_q;
  logic         in_fire, main_free;

  assign in_ready_o  = ~skid_valid_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign main_free   = ~main_valid_q | out_ready_i;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign empty_o     = ~main_valid_q & ~skid_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_data_q  <= skid_data_q;
        main_valid_q <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= in_fire;
        if (in_fire) main_data_q <= in_data_i;
      end
    end else if (in_fire) begin
      // Output stalled: park the beat accepted on the strength of last cycle's ready.
      skid_data_q  <= in_data_i;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/axis_frame_ctrl.sv
// Inserts TLAST every cfg_frame_len beats on a TLAST-less stream and runs for a
// programmed number of frames, zero-extending data to the DMA width.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting input and marking frame boundaries
// DRAIN | input closed, emptying the skid buffer
// DONE  | run finished, waiting for the next start
module axis_frame_ctrl
  import axis_frame_pkg::*;
#(
  parameter int IN_DATA_WIDTH  = DEF_IN_W,
  parameter int OUT_DATA_WIDTH = DEF_OUT_W,
  parameter int LEN_WIDTH      = DEF_LEN_W,
  parameter int CNT_WIDTH      = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_start,
  input  logic                      cfg_abort,
  input  logic [LEN_WIDTH-1:0]      cfg_frame_len,
  input  logic [CNT_WIDTH-1:0]      cfg_num_frames,
  output logic                      status_busy,
  output logic                      status_done,
  output logic                      status_err_len,
  output logic [CNT_WIDTH-1:0]      status_frames,
  input  logic                      s_axis_tvalid,
  input  logic [IN_DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                      s_axis_tready,
  output logic                      m_axis_tvalid,
  output logic [OUT_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready
);

  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]    num_q, frame_in_q, frames_q;
  logic                    stop_q, pend_q, err_q;
  logic                    idle_like, start_ok, start_bad;
  logic                    s_fire, m_fire, is_last, final_beat, abort_now, stop_now;
  logic                    skid_in_ready, skid_empty;
  logic [OUT_DATA_WIDTH:0] skid_in_word, skid_out_word;

  assign idle_like     = (state_q == IDLE) || (state_q == DONE);
  assign start_ok      = idle_like & cfg_start & (cfg_frame_len != '0);
  assign start_bad     = idle_like & cfg_start & (cfg_frame_len == '0);
  assign s_axis_tready = (state_q == RUN) & skid_in_ready & ~stop_q;
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign m_fire        = m_axis_tvalid & m_axis_tready;
  assign is_last       = (beat_cnt_q == len_q - LEN_WIDTH'(1));
  assign final_beat    = (num_q != '0) && (frame_in_q + CNT_WIDTH'(1) == num_q);
  assign beat_cnt_d    = s_fire ? (is_last ? '0 : beat_cnt_q + LEN_WIDTH'(1)) : beat_cnt_q;
  // Abort is honoured at once only on a frame boundary, counting this cycle's beat.
  assign abort_now     = (state_q == RUN) & cfg_abort & (beat_cnt_d == '0);
  assign stop_now      = (s_fire & is_last & (final_beat | pend_q)) | abort_now;

  assign skid_in_word  = {is_last, OUT_DATA_WIDTH'(zext(ZEXT_MAX_W'(s_axis_tdata), IN_DATA_WIDTH))};
  assign m_axis_tlast  = skid_out_word[OUT_DATA_WIDTH];
  assign m_axis_tdata  = skid_out_word[OUT_DATA_WIDTH-1:0];

  assign status_err_len = err_q;
  assign status_frames  = frames_q;

  axis_skid_buf #(.W(OUT_DATA_WIDTH + 1)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (s_fire),
    .in_data_i   (skid_in_word),
    .in_ready_o  (skid_in_ready),
    .out_valid_o (m_axis_tvalid),
    .out_data_o  (skid_out_word),
    .out_ready_i (m_axis_tready),
    .empty_o     (skid_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_ok) state_d = RUN;
      RUN:        if (stop_now) state_d = DRAIN;
      DRAIN:      if (skid_empty) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    status_busy = 1'b0;
    status_done = 1'b0;
    unique case (state_q)
      RUN, DRAIN: status_busy = 1'b1;
      DONE:       status_done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      num_q      <= '0;
      beat_cnt_q <= '0;
      frame_in_q <= '0;
      frames_q   <= '0;
      stop_q     <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (start_ok) begin
      len_q      <= cfg_frame_len;
      num_q      <= cfg_num_frames;
      beat_cnt_q <= '0;
      frame_in_q <= '0;
      frames_q   <= '0;
      stop_q     <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (start_bad) err_q <= 1'b1;
      beat_cnt_q <= beat_cnt_d;
      if (s_fire & is_last) frame_in_q <= frame_in_q + CNT_WIDTH'(1);
      if (stop_now) stop_q <= 1'b1;
      if ((state_q == RUN) & cfg_abort & (beat_cnt_d != '0)) pend_q <= 1'b1;
      if (m_fire & m_axis_tlast) frames_q <= frames_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/axis_frame_ctrl.md
Name: axis_frame_ctrl

Overview:
- Sequences the FINN-output-to-DMA AXIS path: takes a TLAST-less model stream, marks frame boundaries with TLAST every cfg_frame_len beats and zero-extends data to the DMA width.
- Runs for a programmed number of frames per start command, then stops accepting input, so each DMA transfer matches exactly one configured frame.
- Sits between the model output FIFO and the DMA S2MM port; configured from a register block.

Parameters:
- IN_DATA_WIDTH, 8, model-side tdata width
- OUT_DATA_WIDTH, 32, DMA-side tdata width (must be >= IN_DATA_WIDTH)
- LEN_WIDTH, 16, width of the beats-per-frame count
- CNT_WIDTH, 16, width of the frame count

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_start  in  1  one-cycle start pulse
- cfg_abort  in  1  one-cycle pulse; stop at the next frame boundary
- cfg_frame_len  in  LEN_WIDTH  beats per frame, sampled on an accepted start
- cfg_num_frames  in  CNT_WIDTH  frames per run, sampled on an accepted start; 0 = unbounded
- status_busy  out  1  high in RUN or DRAIN
- status_done  out  1  high in DONE
- status_err_len  out  1  sticky; start was attempted with cfg_frame_len == 0
- status_frames  out  CNT_WIDTH  frames fully emitted on the master side in the current run
- s_axis_tvalid  in  1
- s_axis_tdata  in  IN_DATA_WIDTH
- s_axis_tready  out  1
- m_axis_tvalid  out  1
- m_axis_tdata  out  OUT_DATA_WIDTH  upper bits are 0
- m_axis_tlast  out  1
- m_axis_tready  in  1

Behaviour:
- Reset (async, rst=1): state IDLE; all counters 0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, all status outputs 0; skid buffer emptied.
- FSM states:
  - IDLE/DONE --start & len!=0--> RUN: latch len and num_frames, clear beat_cnt, frame_in, status_frames and status_err_len.
  - IDLE/DONE + start & len==0: set status_err_len; stay in current state.
  - RUN --final-frame last beat accepted, or abort honoured--> DRAIN.
  - DRAIN --buffer empty--> DONE.
- cfg_start outside IDLE/DONE: ignored.
- Datapath:
  - s_axis_tready = (state==RUN) & skid_in_ready & ~stop.
  - An accepted input beat gets tlast = (beat_cnt == len-1).
  - beat_cnt wraps to 0 on that beat; frame_in increments on it.
- Latency and throughput: 1 cycle from s-handshake to m_axis_tvalid; 1 beat/cycle sustained; m_axis_tready may be low indefinitely.
- Skid buffer is 2 entries. Registered outputs; no combinational path from m_axis_tready to s_axis_tready.
- AXIS rules: once m_axis_tvalid=1, tdata and tlast are held until handshake. Buffered data is never dropped except by reset.
- Frame termination: when num_frames != 0 and frame_in reaches num_frames, stop=1 on that same accepted beat, so tready is low from the next cycle.
- status_frames increments on each master handshake with tlast=1.
- Abort:
  - In RUN with beat_cnt==0: stop immediately, go to DRAIN.
  - Mid-frame: set stop_pending; go to DRAIN when the current frame's last beat is accepted. Frames are never truncated.
  - Abort in other states: ignored.
- Simultaneous start+abort in IDLE: start wins; abort is ignored.
- Counters do not saturate: status_frames wraps modulo 2^CNT_WIDTH when num_frames==0.
- len==1: every beat carries tlast.

Decomposition:
- Package axis_frame_pkg:
  - state_e enum {IDLE, RUN, DRAIN, DONE}
  - ZEXT helper
  - default width constants
- Sub-module axis_skid_buf (2-entry register slice carrying {tlast, tdata}) is natural and reusable across the stream path.

Test Plan:
- Basic run: len=4, frames=2, continuous input 0x01..0x08, m_tready=1 -> 8 output beats 0x00000001..0x00000008; tlast on beats 4 and 8; status_frames=2; DONE; s_tready=0 afterwards.
- Backpressure: len=3, frames=1, m_tready toggling 1/0 each cycle -> data order preserved; tdata and tlast stable while stalled; exactly one tlast; no extra input accepted after beat 3.
- Abort mid-frame: len=5, frames=0, abort after the 7th accepted beat -> input continues to beat 10 then stops; tlast on beats 5 and 10; DONE; status_frames=2.
- Zero-length start: cfg_frame_len=0 + start -> status_err_len=1, FSM stays IDLE, s_tready=0. A following valid start clears err_len.
- Reset mid-operation: assert rst while m_tvalid=1 in RUN -> same cycle m_tvalid=0, s_tready=0, IDLE. A new start with len=2 yields tlast on beat 2.
- len=1, frames=3 with start pulsed again while in RUN -> second start ignored; 3 beats, each with tlast; DONE.
